// File: rtl/sram_arbiter.sv
// Multi-cycle controller for the shared board SRAM: serialises instruction fetch and data
// access (data has priority) and sequences the active-low strobes and bus-driver enable.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [15:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_ready,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dout,
  input  logic [15:0]       ram_din,
  output logic              ram_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } state_e;

  state_e     state;
  logic [2:0] cnt;
  logic       owner_mem;

  assign stall = (if_req & ~if_ready) | ((mem_read | mem_write) & ~mem_ready);

  // All SRAM-facing outputs are registered and updated on state transitions so the pins
  // never glitch; ram_oe and we_n are always moved on different edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= 3'd0;
      owner_mem <= 1'b0;
      ram_addr  <= '0;
      ram_dout  <= 16'h0000;
      ram_oe    <= 1'b0;
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      if_rdata  <= 16'h0000;
      mem_rdata <= 16'h0000;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      unique case (state)
        StIdle: begin
          if (mem_read || mem_write) begin
            owner_mem <= 1'b1;
            ram_addr  <= ADDR_W'(mem_addr);
            ram_ce_n  <= 1'b0;
            cnt       <= 3'(WAIT_CYCLES);
            if (mem_write) begin
              ram_dout <= mem_wdata;
              ram_oe   <= 1'b1;
              state    <= StWrSetup;
            end else begin
              ram_oe_n <= 1'b0;
              state    <= StRd;
            end
          end else if (if_req) begin
            owner_mem <= 1'b0;
            ram_addr  <= ADDR_W'(if_addr);
            ram_ce_n  <= 1'b0;
            ram_oe_n  <= 1'b0;
            cnt       <= 3'(WAIT_CYCLES);
            state     <= StRd;
          end
        end
        StRd: begin
          if (cnt == 3'd0) begin
            if (owner_mem) begin
              mem_rdata <= ram_din;
              mem_ready <= 1'b1;
            end else begin
              if_rdata <= ram_din;
              if_ready <= 1'b1;
            end
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            state    <= StDone;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        StWrSetup: begin
          ram_we_n <= 1'b0;
          cnt      <= 3'(WAIT_CYCLES);
          state    <= StWrPulse;
        end
        StWrPulse: begin
          if (cnt == 3'd0) begin
            ram_we_n <= 1'b1;
            state    <= StWrHold;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        StWrHold: begin
          ram_ce_n <= 1'b1;
          ram_oe   <= 1'b0;
          if (owner_mem) mem_ready <= 1'b1;
          else           if_ready  <= 1'b1;
          state <= StDone;
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: instance 0 uses WAIT_CYCLES=1, instance 1 WAIT_CYCLES=0,
// each with its own behavioural SRAM.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        if_req    [2];
  logic [15:0] if_addr   [2];
  logic [15:0] if_rdata  [2];
  logic        if_ready  [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        mem_ready [2];
  logic        stall     [2];
  logic [17:0] ram_addr  [2];
  logic [15:0] ram_dout  [2];
  logic [15:0] ram_din   [2];
  logic        ram_oe    [2];
  logic        ram_ce_n  [2];
  logic        ram_oe_n  [2];
  logic        ram_we_n  [2];

  logic [15:0] sram0 [65536];
  logic [15:0] sram1 [65536];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_mem;
    logic [15:0] data;
    bit          chk_data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(18)) dut0 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
    .stall(stall[0]), .ram_addr(ram_addr[0]), .ram_dout(ram_dout[0]), .ram_din(ram_din[0]),
    .ram_oe(ram_oe[0]), .ram_ce_n(ram_ce_n[0]), .ram_oe_n(ram_oe_n[0]), .ram_we_n(ram_we_n[0])
  );

  sram_arbiter #(.WAIT_CYCLES(0), .ADDR_W(18)) dut1 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
    .stall(stall[1]), .ram_addr(ram_addr[1]), .ram_dout(ram_dout[1]), .ram_din(ram_din[1]),
    .ram_oe(ram_oe[1]), .ram_ce_n(ram_ce_n[1]), .ram_oe_n(ram_oe_n[1]), .ram_we_n(ram_we_n[1])
  );

  // SRAM models; a read outside an enabled window returns a poison value
  always @(posedge clk) begin
    if (!ram_ce_n[0] && !ram_we_n[0]) sram0[ram_addr[0][15:0]] <= ram_dout[0];
    if (!ram_ce_n[1] && !ram_we_n[1]) sram1[ram_addr[1][15:0]] <= ram_dout[1];
  end
  assign ram_din[0] = (!ram_ce_n[0] && !ram_oe_n[0]) ? sram0[ram_addr[0][15:0]] : 16'hDEAD;
  assign ram_din[1] = (!ram_ce_n[1] && !ram_oe_n[1]) ? sram1[ram_addr[1][15:0]] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop_cmp(input int d, input bit is_mem, input logic [15:0] data);
    exp_t e;
    bit   empty;
    empty = 1'b0;
    if (d == 0) begin
      if (q0.size() == 0) empty = 1'b1;
      else e = q0.pop_front();
    end else begin
      if (q1.size() == 0) empty = 1'b1;
      else e = q1.pop_front();
    end
    checks++;
    if (empty || e.is_mem != is_mem) begin
      errors++;
      $display("FAIL sb_kind dut%0d: got ready is_mem=%0d expected %s", d, is_mem,
               empty ? "no ready" : (e.is_mem ? "mem_ready" : "if_ready"));
    end else begin
      chk($sformatf("sb_cycle dut%0d", d), cyc, e.cyc);
      if (e.chk_data) chk($sformatf("sb_rdata dut%0d", d), {16'h0, data}, {16'h0, e.data});
    end
  endtask

  // Monitor: every ready pulse is matched against the scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        if (if_ready[d])  pop_cmp(d, 1'b0, if_rdata[d]);
        if (mem_ready[d]) pop_cmp(d, 1'b1, mem_rdata[d]);
      end
    end
  end

  task automatic wait_ready(input int d, input bit is_mem);
    int n;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (is_mem ? mem_ready[d] : if_ready[d]) break;
      n++;
    end
    if (n == 30) chk($sformatf("ready_timeout dut%0d", d), 0, 1);
  endtask

  task automatic access(input int d, input bit is_mem, input bit wr, input bit rd,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_d, input int lat);
    exp_t e;
    @(posedge clk); #1;
    if (is_mem) begin
      mem_addr[d]  = a;
      mem_wdata[d] = wd;
      mem_write[d] = wr;
      mem_read[d]  = rd;
    end else begin
      if_addr[d] = a;
      if_req[d]  = 1'b1;
    end
    e = '{is_mem, exp_d, !wr, cyc + lat};
    push(d, e);
    wait_ready(d, is_mem);
    @(posedge clk); #1;
    if_req[d]    = 1'b0;
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] e_oe, e_we_n, e_ce_n;
    int c;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; if_req[d] = 1'b0; if_addr[d] = 16'h0; mem_read[d] = 1'b0;
      mem_write[d] = 1'b0; mem_addr[d] = 16'h0; mem_wdata[d] = 16'h0;
    end
    sram0[4] = 16'h4A12;
    sram1[4] = 16'h4A12;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ce_n", ram_ce_n[d], 1);
      chk("rst_oe_n", ram_oe_n[d], 1);
      chk("rst_we_n", ram_we_n[d], 1);
      chk("rst_ram_oe", ram_oe[d], 0);
      chk("rst_ram_addr", ram_addr[d], 0);
      chk("rst_ram_dout", ram_dout[d], 0);
      chk("rst_if_rdata", if_rdata[d], 0);
      chk("rst_mem_rdata", mem_rdata[d], 0);
      chk("rst_if_ready", if_ready[d], 0);
      chk("rst_mem_ready", mem_ready[d], 0);
      chk("rst_stall", stall[d], 0);
      rst[d] = 1'b0;
    end

    // IF read of 0x0004, WAIT_CYCLES=1: ready in cycle 3, stall high 0..2
    @(posedge clk); #1;
    if_addr[0] = 16'h0004; if_req[0] = 1'b1;
    push(0, '{1'b0, 16'h4A12, 1'b1, cyc + 3});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("if_rd_stall k%0d", k), stall[0], (k < 3) ? 1 : 0);
      if (k == 1) begin
        chk("rd_ce_n", ram_ce_n[0], 0);
        chk("rd_oe_n", ram_oe_n[0], 0);
        chk("rd_we_n", ram_we_n[0], 1);
        chk("rd_ram_oe", ram_oe[0], 0);
        chk("rd_addr", ram_addr[0], 18'h00004);
      end
    end
    @(posedge clk); #1; if_req[0] = 1'b0;

    // MEM write 0x1234 to 0x8000: ram_oe cycles 1..4, we_n low cycles 2..3, ready cycle 5
    e_oe = 6'b011110; e_we_n = 6'b110011; e_ce_n = 6'b100001;
    @(posedge clk); #1;
    mem_addr[0] = 16'h8000; mem_wdata[0] = 16'h1234; mem_write[0] = 1'b1;
    push(0, '{1'b1, 16'h0000, 1'b0, cyc + 5});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("wr_ram_oe k%0d", k), ram_oe[0], e_oe[k]);
      chk($sformatf("wr_we_n k%0d", k), ram_we_n[0], e_we_n[k]);
      chk($sformatf("wr_ce_n k%0d", k), ram_ce_n[0], e_ce_n[k]);
      if (k == 2) begin
        chk("wr_dout", ram_dout[0], 16'h1234);
        chk("wr_addr", ram_addr[0], 18'h08000);
      end
    end
    @(posedge clk); #1; mem_write[0] = 1'b0;
    access(0, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0, 16'h1234, 3);

    // Simultaneous if_req and mem_read: MEM ready cycle 3, IF ready cycle 7
    @(posedge clk); #1;
    if_addr[0] = 16'h0004; if_req[0] = 1'b1;
    mem_addr[0] = 16'h8000; mem_read[0] = 1'b1;
    push(0, '{1'b1, 16'h1234, 1'b1, cyc + 3});
    push(0, '{1'b0, 16'h4A12, 1'b1, cyc + 7});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("prio_stall k%0d", k), stall[0], (k < 7) ? 1 : 0);
      if (k == 3) begin
        @(posedge clk); #1; mem_read[0] = 1'b0;
      end
    end
    @(posedge clk); #1; if_req[0] = 1'b0;

    // mem_read and mem_write together behave as a write
    access(0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 5);
    access(0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 16'hBEEF, 3);

    // Reset in WR_PULSE: strobes drop asynchronously and no ready follows
    @(posedge clk); #1;
    mem_addr[0] = 16'h0020; mem_wdata[0] = 16'h5555; mem_write[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_we_n", ram_we_n[0], 0);
    #1 rst[0] = 1'b1;
    #1;
    chk("arst_ce_n", ram_ce_n[0], 1);
    chk("arst_oe_n", ram_oe_n[0], 1);
    chk("arst_we_n", ram_we_n[0], 1);
    chk("arst_ram_oe", ram_oe[0], 0);
    mem_write[0] = 1'b0;
    #1 rst[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("arst_no_ready k%0d", k), mem_ready[0], 0);
    end
    access(0, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, 16'h4A12, 3);

    // WAIT_CYCLES=0 instance
    access(1, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, 16'h4A12, 2);
    access(1, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h00AA, 16'h0, 4);
    access(1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0, 16'h00AA, 2);
    @(posedge clk); #1;
    if_addr[1] = 16'h0004; if_req[1] = 1'b1;
    c = cyc;
    push(1, '{1'b0, 16'h4A12, 1'b1, c + 2});
    push(1, '{1'b0, 16'h4A12, 1'b1, c + 5});
    push(1, '{1'b0, 16'h4A12, 1'b1, c + 8});
    repeat (9) @(negedge clk);
    @(posedge clk); #1; if_req[1] = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_empty", q0.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
